md_ctrl: RTL and testbench

Multiply/divide sequencer for the five-stage pipeline. It owns the HI/LO register pair and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage. It models multi-cycle latency with a countdown and raises a stall request so the hazard unit freezes PC/D and clears E while a HI/LO-dependent instruction waits in D. MFHI/MFLO read data is returned combinationally to the E-stage result mux.

---
 rtl/md_pkg.sv | 20 ++
 rtl/md_arith.sv | 58 +++++
 rtl/md_ctrl.sv | 80 ++++++++
 tb/tb_md_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Multiply/divide unit shared definitions.
// Opcode encoding and start-op classification.
package md_pkg;

    localparam logic [3:0] MD_NONE = 4'd0;
    localparam logic [3:0] MULT    = 4'd1;
    localparam logic [3:0] MULTU   = 4'd2;
    localparam logic [3:0] DIV     = 4'd3;
    localparam logic [3:0] DIVU    = 4'd4;
    localparam logic [3:0] MFHI    = 4'd5;
    localparam logic [3:0] MFLO    = 4'd6;
    localparam logic [3:0] MTHI    = 4'd7;
    localparam logic [3:0] MTLO    = 4'd8;

    // True for ops that launch a multi-cycle computation
    function automatic logic is_start(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply/divide datapath.
// Produces {hi,lo} including divide-by-zero and overflow results.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mq;
    logic [31:0] mr;
    logic [31:0] sq;
    logic [31:0] sr;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign uq = a / b;
    assign ur = a % b;

    // Signed divide through magnitudes: avoids the INT_MIN / -1 overflow
    // trap and yields 0x80000000 rem 0 naturally.
    assign mag_a = a[31] ? -a : a;
    assign mag_b = b[31] ? -b : b;
    assign mq    = mag_a / mag_b;
    assign mr    = mag_a % mag_b;
    assign sq    = (a[31] ^ b[31]) ? -mq : mq;
    assign sr    = a[31] ? -mr : mr;

    // Select result for the requested operation
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MULT:  {res_hi, res_lo} = prod_s;
            MULTU: {res_hi, res_lo} = prod_u;
            DIV: begin
                if (b == '0) {res_hi, res_lo} = {a, 32'hFFFF_FFFF};
                else         {res_hi, res_lo} = {sr, sq};
            end
            DIVU: begin
                if (b == '0) {res_hi, res_lo} = {a, 32'hFFFF_FFFF};
                else         {res_hi, res_lo} = {ur, uq};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO owner and multi-cycle multiply/divide sequencer.
// Raises stall_md while a dependent instruction waits in D.
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_e,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hilo_rd_e,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAXC =
        (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] n_start;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          start;
    logic          is_mul;

    md_arith u_arith (
        .op     (md_op_e),
        .a      (rs_e),
        .b      (rt_e),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign start   = is_start(md_op_e) & ~busy;
    assign is_mul  = (md_op_e == MULT) || (md_op_e == MULTU);
    assign n_start = is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);

    assign stall_md = md_use_d & (start | busy);

    assign hilo_rd_e = (md_op_e == MFHI) ? hi :
                       (md_op_e == MFLO) ? lo : 32'd0;

    // Launch, count down and commit; MTHI/MTLO only when idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                hi   <= pend_hi;
                lo   <= pend_lo;
                busy <= 1'b0;
            end
        end else if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            cnt     <= n_start;
            busy    <= 1'b1;
        end else if (md_op_e == MTHI) begin
            hi <= rs_e;
        end else if (md_op_e == MTLO) begin
            lo <= rs_e;
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: vector table, directed
// pipeline sequences and a randomized reference-model run.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int NMUL = 5;
    localparam int NDIV = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op_e;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hilo_rd_e;
    logic [31:0] hi;
    logic [31:0] lo;

    int errs = 0;
    int checks = 0;

    md_ctrl #(.MUL_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_op_e   (md_op_e),
        .rs_e      (rs_e),
        .rt_e      (rt_e),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .stall_md  (stall_md),
        .hilo_rd_e (hilo_rd_e),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          n;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: architectural result from plain integer arithmetic
    function automatic logic [63:0] ref_calc(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == MULT) return 64'(sa * sb);
        if (op == MULTU) return ua * ub;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'((ua % ub)), 32'((ua / ub))};
    endfunction

    task automatic idle_inputs();
        md_op_e  = MD_NONE;
        rs_e     = '0;
        rt_e     = '0;
        md_use_d = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Issue one start op, then count busy cycles (bounded)
    task automatic run_op(input string name, input vec_t v);
        int nb;
        @(negedge clk);
        md_op_e = v.op;
        rs_e    = v.rs;
        rt_e    = v.rt;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        nb = 0;
        #1;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            @(negedge clk);
            #1;
        end
        chk({name, "_busy_cycles"}, 32'(nb), 32'(v.n));
        chk({name, "_hi"}, hi, v.ehi);
        chk({name, "_lo"}, lo, v.elo);
    endtask

    // Randomized run against a commit-time reference model
    task automatic random_run(input int cycles);
        int          ec;
        int          commit;
        logic [31:0] m_hi;
        logic [31:0] m_lo;
        logic [31:0] p_hi;
        logic [31:0] p_lo;
        logic        m_busy;
        logic        m_start;
        logic [63:0] r;
        logic [31:0] ex_rd;
        int          sel;
        do_reset();
        ec = 0;
        commit = 0;
        m_hi = '0;
        m_lo = '0;
        p_hi = '0;
        p_lo = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            md_op_e  = 4'($urandom_range(0, 8));
            rs_e     = $urandom;
            sel      = int'($urandom_range(0, 7));
            rt_e     = (sel == 0) ? 32'd0 :
                       (sel == 1) ? 32'hFFFF_FFFF : $urandom;
            if (sel == 1 && $urandom_range(0, 1) == 1) rs_e = 32'h8000_0000;
            md_use_d = 1'($urandom_range(0, 1));
            #1;
            m_busy  = (ec < commit);
            m_start = !m_busy && (md_op_e inside {MULT, MULTU, DIV, DIVU});
            ex_rd   = (md_op_e == MFHI) ? m_hi :
                      (md_op_e == MFLO) ? m_lo : 32'd0;
            chk("rnd_busy", 32'(busy), 32'(m_busy));
            chk("rnd_stall", 32'(stall_md),
                32'(md_use_d & (m_busy | m_start)));
            chk("rnd_hi", hi, m_hi);
            chk("rnd_lo", lo, m_lo);
            chk("rnd_rd", hilo_rd_e, ex_rd);
            @(posedge clk);
            ec++;
            if (m_busy) begin
                if (ec == commit) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end else if (m_start) begin
                r = ref_calc(md_op_e, rs_e, rt_e);
                p_hi = r[63:32];
                p_lo = r[31:0];
                commit = ec +
                    ((md_op_e == MULT || md_op_e == MULTU) ? NMUL : NDIV);
            end else if (md_op_e == MTHI) begin
                m_hi = rs_e;
            end else if (md_op_e == MTLO) begin
                m_lo = rs_e;
            end
        end
    endtask

    initial begin
        vec_t v;
        int   ns;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        @(negedge clk);
        md_use_d = 1'b1;
        md_op_e  = MFHI;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", hilo_rd_e, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();

        // Vector table; entries run back to back
        vt.push_back('{MULT,  32'hFFFF_FFFF, 32'd2, NMUL,
                       32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vt.push_back('{MULTU, 32'hFFFF_FFFF, 32'd2, NMUL,
                       32'h0000_0001, 32'hFFFF_FFFE});
        vt.push_back('{DIV,   32'hFFFF_FFF9, 32'd2, NDIV,
                       32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vt.push_back('{DIVU,  32'd7, 32'd0, NDIV,
                       32'd7, 32'hFFFF_FFFF});
        vt.push_back('{DIV,   32'h8000_0000, 32'hFFFF_FFFF, NDIV,
                       32'd0, 32'h8000_0000});
        vt.push_back('{MULTU, 32'h0001_0000, 32'h0001_0000, NMUL,
                       32'd1, 32'd0});
        vt.push_back('{DIV,   32'd7, 32'hFFFF_FFFE, NDIV,
                       32'd1, 32'hFFFF_FFFD});
        vt.push_back('{DIV,   32'hFFFF_FFFB, 32'd0, NDIV,
                       32'hFFFF_FFFB, 32'hFFFF_FFFF});
        vt.push_back('{DIVU,  32'hFFFF_FFFF, 32'd3, NDIV,
                       32'd0, 32'h5555_5555});
        for (int i = 0; i < vt.size(); i++)
            run_op($sformatf("vec%0d", i), vt[i]);

        // MULT with MFLO waiting in D
        @(negedge clk);
        md_op_e  = MULT;
        rs_e     = 32'd3;
        rt_e     = 32'hFFFF_FFFF;
        md_use_d = 1'b1;
        #1;
        chk("stall_start_cycle", 32'(stall_md), 32'd1);
        ns = 1;
        @(posedge clk);
        @(negedge clk);
        md_op_e = MD_NONE;
        #1;
        while (stall_md === 1'b1 && ns < 40) begin
            ns++;
            @(negedge clk);
            #1;
        end
        chk("stall_total", 32'(ns), 32'(NMUL + 1));
        md_op_e  = MFLO;
        md_use_d = 1'b0;
        #1;
        chk("mflo_rd", hilo_rd_e, 32'hFFFF_FFFD);
        md_op_e = MFHI;
        #1;
        chk("mfhi_rd", hilo_rd_e, 32'hFFFF_FFFF);

        // MTHI while idle
        @(negedge clk);
        md_op_e = MTHI;
        rs_e    = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", 32'(busy), 32'd0);

        // MTLO ignored during DIV
        @(negedge clk);
        md_op_e = DIV;
        rs_e    = 32'd100;
        rt_e    = 32'd7;
        @(posedge clk);
        @(negedge clk);
        md_op_e = MTLO;
        rs_e    = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mtlo_busy_lo", lo, 32'hFFFF_FFFD);
        repeat (NDIV) @(posedge clk);
        @(negedge clk);
        #1;
        chk("div_after_mtlo_lo", lo, 32'd14);
        chk("div_after_mtlo_hi", hi, 32'd2);

        // Reset during the 3rd busy cycle of a DIV
        @(negedge clk);
        md_op_e = DIV;
        rs_e    = 32'd50;
        rt_e    = 32'd3;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        md_use_d = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_stall", 32'(stall_md), 32'd0);
        repeat (NDIV + 3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("no_late_commit_hi", hi, 32'd0);
        chk("no_late_commit_lo", lo, 32'd0);

        random_run(1500);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
